// File: rtl/datapath_seq_pkg.sv
// Op encodings, FSM states and bus-source codes shared by the datapath_seq files.
// DATAPATH_SEQ_MUL_EN makes MUL/MFHI/MFLO legal ops.
package datapath_seq_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_SHL  = 4'h4;
  localparam logic [3:0] OP_SHR  = 4'h5;
  localparam logic [3:0] OP_LDI  = 4'h6;
  localparam logic [3:0] OP_MOV  = 4'h7;
  localparam logic [3:0] OP_MUL  = 4'h8;
  localparam logic [3:0] OP_MFHI = 4'h9;
  localparam logic [3:0] OP_MFLO = 4'hA;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TA   = 2'd1,
    TB   = 2'd2,
    TW   = 2'd3
  } state_t;

  typedef enum logic [4:0] {
    SRC_NONE = 5'b00000,
    SRC_REG  = 5'b00001,
    SRC_ZLO  = 5'b00010,
    SRC_IMM  = 5'b00100,
    SRC_HI   = 5'b01000,
    SRC_LO   = 5'b10000
  } bus_src_t;

  function automatic logic is_legal(input logic [3:0] op);
`ifdef DATAPATH_SEQ_MUL_EN
    return op <= OP_MFLO;
`else
    return op <= OP_MOV;
`endif
  endfunction

  function automatic logic is_two_src(input logic [3:0] op);
    return (op <= OP_SHR) || (op == OP_MUL);
  endfunction

  function automatic logic uses_ra(input logic [3:0] op);
    return is_two_src(op) || (op == OP_MOV);
  endfunction

  // MUL lands in HI/LO, so its rd field is never checked or written.
  function automatic logic uses_rd(input logic [3:0] op);
    return op != OP_MUL;
  endfunction

endpackage

// File: rtl/datapath_seq_alu.sv
// Combinational ALU: (op, Y, bus) -> double-width Z.
// MUL produces a full product only when DATAPATH_SEQ_MUL_EN is defined.
module datapath_seq_alu
  import datapath_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] z
);
  localparam int SW = $clog2(WIDTH);

  logic [SW-1:0] sh;
  assign sh = b[SW-1:0];

  always_comb begin
    z = '0;
    case (op)
      OP_ADD: z[WIDTH-1:0] = a + b;
      OP_SUB: z[WIDTH-1:0] = a - b;
      OP_AND: z[WIDTH-1:0] = a & b;
      OP_OR:  z[WIDTH-1:0] = a | b;
      OP_SHL: z[WIDTH-1:0] = a << sh;
      OP_SHR: z[WIDTH-1:0] = a >> sh;
`ifdef DATAPATH_SEQ_MUL_EN
      OP_MUL: z = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
`endif
      default: z = '0;
    endcase
  end

endmodule

// File: rtl/datapath_seq.sv
// Self-sequenced single-bus datapath: register file, Y, Z and optional HI/LO driven by a T-state FSM.
// DATAPATH_SEQ_MUL_EN adds HI/LO and the MUL/MFHI/MFLO ops.
module datapath_seq
  import datapath_seq_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int NUM_REGS = 16
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [3:0]       op_code,
  input  logic [4:0]       op_ra,
  input  logic [4:0]       op_rb,
  input  logic [4:0]       op_rd,
  input  logic [WIDTH-1:0] op_imm,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result,
  input  logic [4:0]       dbg_sel,
  output logic [WIDTH-1:0] dbg_data,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);
  localparam int         RW    = $clog2(NUM_REGS);
  localparam logic [5:0] NREGS = 6'(NUM_REGS);

  state_t                         state;
  logic [3:0]                     op_q;
  logic [RW-1:0]                  ra_q, rb_q, rd_q, rsel;
  logic [WIDTH-1:0]               imm_q, y, bus;
  logic                           bad_q, ok;
  logic [NUM_REGS-1:0][WIDTH-1:0] rf;
  logic [2*WIDTH-1:0]             z, alu_z;
  bus_src_t                       src;

`ifdef DATAPATH_SEQ_MUL_EN
  logic [WIDTH-1:0] hi, lo;
  assign hi_out = hi;
  assign lo_out = lo;
`else
  logic unused_zhi;
  assign hi_out     = '0;
  assign lo_out     = '0;
  assign unused_zhi = ^z[2*WIDTH-1:WIDTH];
`endif

  function automatic logic idx_ok(input logic [4:0] idx);
    return {1'b0, idx} < NREGS;
  endfunction

  // Full 5-bit indices are range-checked here; only RW bits are latched.
  assign ok = is_legal(op_code)
           && (!uses_ra(op_code)    || idx_ok(op_ra))
           && (!is_two_src(op_code) || idx_ok(op_rb))
           && (!uses_rd(op_code)    || idx_ok(op_rd));

  assign op_ready = (state == IDLE);
  assign dbg_data = idx_ok(dbg_sel) ? rf[dbg_sel[RW-1:0]] : '0;
  assign rsel     = (state == TB) ? rb_q : ra_q;

  always_comb begin
    src = SRC_NONE;
    case (state)
      TA, TB: src = SRC_REG;
      TW: begin
        if (bad_q) src = SRC_ZLO;
        else begin
          case (op_q)
            OP_LDI:  src = SRC_IMM;
            OP_MOV:  src = SRC_REG;
            OP_MFHI: src = SRC_HI;
            OP_MFLO: src = SRC_LO;
            default: src = SRC_ZLO;
          endcase
        end
      end
      default: src = SRC_NONE;
    endcase
  end

  always_comb begin
    bus = '0;
    case (src)
      SRC_REG: bus = rf[rsel];
      SRC_ZLO: bus = z[WIDTH-1:0];
      SRC_IMM: bus = imm_q;
`ifdef DATAPATH_SEQ_MUL_EN
      SRC_HI:  bus = hi;
      SRC_LO:  bus = lo;
`endif
      default: bus = '0;
    endcase
  end

  datapath_seq_alu #(.WIDTH(WIDTH)) u_alu (
    .op (op_q),
    .a  (y),
    .b  (bus),
    .z  (alu_z)
  );

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state  <= IDLE;
      op_q   <= '0;
      ra_q   <= '0;
      rb_q   <= '0;
      rd_q   <= '0;
      imm_q  <= '0;
      bad_q  <= 1'b0;
      rf     <= '0;
      y      <= '0;
      z      <= '0;
      result <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
`ifdef DATAPATH_SEQ_MUL_EN
      hi     <= '0;
      lo     <= '0;
`endif
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: if (op_valid) begin
          op_q  <= op_code;
          ra_q  <= op_ra[RW-1:0];
          rb_q  <= op_rb[RW-1:0];
          rd_q  <= op_rd[RW-1:0];
          imm_q <= op_imm;
          bad_q <= !ok;
          state <= (ok && is_two_src(op_code)) ? TA : TW;
        end
        TA: begin
          y     <= bus;
          state <= TB;
        end
        TB: begin
          z     <= alu_z;
          state <= TW;
        end
        TW: begin
          done  <= 1'b1;
          err   <= bad_q;
          state <= IDLE;
          if (!bad_q) begin
            result <= bus;
`ifdef DATAPATH_SEQ_MUL_EN
            if (op_q == OP_MUL) begin
              hi <= z[2*WIDTH-1:WIDTH];
              lo <= z[WIDTH-1:0];
            end else begin
              rf[rd_q] <= bus;
            end
`else
            rf[rd_q] <= bus;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_datapath_seq.sv
// Table-driven bench for datapath_seq with a done-side scoreboard and hand-written
// back-to-back, busy-ignore and reset-abort sequences; follows DATAPATH_SEQ_MUL_EN.
module tb_datapath_seq;
  import datapath_seq_pkg::*;

  localparam int W  = 32;
  localparam int NR = 16;
`ifdef DATAPATH_SEQ_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         clear, op_valid, op_ready, done, err;
  logic [3:0]   op_code;
  logic [4:0]   op_ra, op_rb, op_rd, dbg_sel;
  logic [W-1:0] op_imm, result, dbg_data, hi_out, lo_out;

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;

  typedef struct {
    logic [3:0]   code;
    logic [4:0]   ra, rb, rd;
    logic [W-1:0] imm;
    logic         err;
    logic [W-1:0] res;
    int           lat;
    logic [4:0]   ci;
    logic [W-1:0] cv;
  } vec_t;

  typedef struct {
    logic         err;
    logic [W-1:0] res;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[22];

  datapath_seq #(.WIDTH(W), .NUM_REGS(NR)) dut (
    .clock    (clock),
    .clear    (clear),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .op_code  (op_code),
    .op_ra    (op_ra),
    .op_rb    (op_rb),
    .op_rd    (op_rd),
    .op_imm   (op_imm),
    .done     (done),
    .err      (err),
    .result   (result),
    .dbg_sel  (dbg_sel),
    .dbg_data (dbg_data),
    .hi_out   (hi_out),
    .lo_out   (lo_out)
  );

  always #5 clock = ~clock;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  always @(negedge clock) begin : mon
    exp_t e;
    if (clear === 1'b1 && done === 1'b1) begin
      done_cnt++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=done result=%h expected=no done", result);
      end else begin
        e = sb.pop_front();
        check("done_err", 64'(err), 64'(e.err));
        check("done_result", 64'(result), 64'(e.res));
      end
    end
  end

  function automatic vec_t mk(input logic [3:0] c, input int ra, input int rb, input int rd,
                              input logic [W-1:0] imm, input logic e, input logic [W-1:0] r,
                              input int lat, input int ci, input logic [W-1:0] cv);
    vec_t v;
    v.code = c;      v.ra  = 5'(ra); v.rb  = 5'(rb); v.rd = 5'(rd);
    v.imm  = imm;    v.err = e;      v.res = r;      v.lat = lat;
    v.ci   = 5'(ci); v.cv  = cv;
    return v;
  endfunction

  task automatic chk_reg(input string nm, input logic [4:0] idx, input logic [W-1:0] val);
    dbg_sel = idx;
    #1;
    check(nm, 64'(dbg_data), 64'(val));
  endtask

  task automatic do_op(input vec_t v, input string nm);
    int lat = 0;
    for (int i = 0; i < 20 && !op_ready; i++) @(negedge clock);
    op_code  = v.code;
    op_ra    = v.ra;
    op_rb    = v.rb;
    op_rd    = v.rd;
    op_imm   = v.imm;
    op_valid = 1'b1;
    sb.push_back('{v.err, v.res});
    @(posedge clock);
    @(negedge clock);
    op_valid = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clock);
      if (done) begin
        lat = i;
        break;
      end
    end
    check({nm, "_latency"}, 64'(lat), 64'(v.lat));
    chk_reg({nm, "_reg"}, v.ci, v.cv);
  endtask

  initial begin
    logic [7:0] pat;
    int d0;

    clear = 1'b0; op_valid = 1'b0; op_code = '0;
    op_ra = '0; op_rb = '0; op_rd = '0; op_imm = '0; dbg_sel = '0;

    tbl[0]  = mk(OP_LDI, 0, 0, 3, 32'h5, 0, 32'h5, 1, 3, 32'h5);
    tbl[1]  = mk(OP_LDI, 0, 0, 4, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFF, 1, 4, 32'hFFFF_FFFF);
    tbl[2]  = mk(OP_ADD, 3, 4, 5, 0, 0, 32'h4, 3, 5, 32'h4);
    tbl[3]  = mk(OP_LDI, 0, 0, 3, 32'h25, 0, 32'h25, 1, 3, 32'h25);
    tbl[4]  = mk(OP_SHL, 3, 3, 6, 0, 0, 32'h4A0, 3, 6, 32'h4A0);
    tbl[5]  = mk(OP_SUB, 3, 4, 7, 0, 0, 32'h26, 3, 7, 32'h26);
    tbl[6]  = mk(OP_SHR, 4, 3, 8, 0, 0, 32'h07FF_FFFF, 3, 8, 32'h07FF_FFFF);
    tbl[7]  = mk(OP_AND, 4, 3, 10, 0, 0, 32'h25, 3, 10, 32'h25);
    tbl[8]  = mk(OP_OR,  6, 3, 11, 0, 0, 32'h4A5, 3, 11, 32'h4A5);
    tbl[9]  = mk(OP_MOV, 11, 0, 12, 0, 0, 32'h4A5, 1, 12, 32'h4A5);
    tbl[10] = mk(OP_ADD, 11, 11, 11, 0, 0, 32'h94A, 3, 11, 32'h94A);
    tbl[11] = mk(4'hF, 0, 0, 3, 32'h99, 1, 32'h94A, 1, 3, 32'h25);
    tbl[12] = mk(OP_ADD, 3, 4, 20, 0, 1, 32'h94A, 1, 4, 32'hFFFF_FFFF);
    tbl[13] = mk(OP_MOV, 16, 0, 12, 0, 1, 32'h94A, 1, 12, 32'h4A5);
    tbl[14] = mk(OP_LDI, 0, 0, 0, 32'h1234_5678, 0, 32'h1234_5678, 1, 0, 32'h1234_5678);
    tbl[15] = mk(OP_ADD, 0, 0, 1, 0, 0, 32'h2468_ACF0, 3, 1, 32'h2468_ACF0);
    tbl[16] = mk(OP_SHL, 0, 3, 2, 0, 0, 32'h468A_CF00, 3, 2, 32'h468A_CF00);
    tbl[17] = mk(OP_LDI, 0, 0, 1, 32'h8000_0000, 0, 32'h8000_0000, 1, 1, 32'h8000_0000);
    tbl[18] = mk(OP_LDI, 0, 0, 2, 32'h4, 0, 32'h4, 1, 2, 32'h4);
    tbl[19] = mk(OP_MUL, 1, 2, 9, 0, !MUL_EN, MUL_EN ? 32'h0 : 32'h4, MUL_EN ? 3 : 1, 9, 32'h0);
    tbl[20] = mk(OP_MFHI, 0, 0, 9, 0, !MUL_EN, MUL_EN ? 32'h2 : 32'h4, 1, 9, MUL_EN ? 32'h2 : 32'h0);
    tbl[21] = mk(OP_MFLO, 0, 0, 13, 0, !MUL_EN, MUL_EN ? 32'h0 : 32'h4, 1, 13, 32'h0);

    repeat (3) @(negedge clock);
    clear = 1'b1;
    #1;
    check("rst_ready", 64'(op_ready), 64'd1);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_hi", 64'(hi_out), 64'd0);
    check("rst_lo", 64'(lo_out), 64'd0);
    chk_reg("rst_r0", 5'd0, '0);
    chk_reg("rst_r31", 5'd31, '0);

    foreach (tbl[i]) do_op(tbl[i], $sformatf("row%0d", i));
    check("mul_hi", 64'(hi_out), MUL_EN ? 64'h2 : 64'h0);
    check("mul_lo", 64'(lo_out), 64'h0);

    // op_valid held high: LDIs are taken every other cycle
    d0 = done_cnt;
    pat = '0;
    op_code = OP_LDI; op_rd = 5'd13; op_imm = 32'hABC; op_valid = 1'b1;
    repeat (3) sb.push_back('{1'b0, 32'hABC});
    for (int i = 0; i < 8; i++) begin
      @(posedge clock);
      @(negedge clock);
      pat[i] = done;
      if (i == 5) op_valid = 1'b0;
    end
    check("b2b_pattern", 64'(pat), 64'(8'b0010_1010));
    check("b2b_count", 64'(done_cnt - d0), 64'd3);
    chk_reg("b2b_r13", 5'd13, 32'hABC);

    // requests while busy must be dropped
    d0 = done_cnt;
    op_code = OP_ADD; op_ra = 5'd4; op_rb = 5'd4; op_rd = 5'd15; op_valid = 1'b1;
    sb.push_back('{1'b0, 32'hFFFF_FFFE});
    @(posedge clock);
    @(negedge clock);
    op_code = OP_LDI; op_rd = 5'd14; op_imm = 32'h77;
    for (int i = 0; i < 6; i++) begin
      @(posedge clock);
      @(negedge clock);
      if (i == 2) op_valid = 1'b0;
    end
    check("busy_count", 64'(done_cnt - d0), 64'd1);
    chk_reg("busy_r14", 5'd14, 32'h0);
    chk_reg("busy_r15", 5'd15, 32'hFFFF_FFFE);
    check("sb_drained", 64'(sb.size()), 64'd0);

    // clear in TB of a two-source op aborts it
    d0 = done_cnt;
    op_code = MUL_EN ? OP_MUL : OP_ADD; op_ra = 5'd1; op_rb = 5'd2; op_rd = 5'd9; op_valid = 1'b1;
    sb.push_back('{1'b0, 32'h0});
    @(posedge clock);
    @(negedge clock);
    op_valid = 1'b0;
    @(posedge clock);
    @(negedge clock);
    clear = 1'b0;
    sb.delete();
    #1;
    check("abort_ready", 64'(op_ready), 64'd1);
    check("abort_done", 64'(done), 64'd0);
    check("abort_err", 64'(err), 64'd0);
    check("abort_result", 64'(result), 64'd0);
    check("abort_hi", 64'(hi_out), 64'd0);
    check("abort_lo", 64'(lo_out), 64'd0);
    for (int i = 0; i < 32; i++) chk_reg($sformatf("abort_r%0d", i), 5'(i), '0);
    @(negedge clock);
    clear = 1'b1;
    repeat (4) @(negedge clock);
    check("abort_no_done", 64'(done_cnt - d0), 64'd0);
    do_op(mk(OP_LDI, 0, 0, 5, 32'h5A, 0, 32'h5A, 1, 5, 32'h5A), "post_reset");
    check("sb_final", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
